// File: rtl/epp_pkg.sv
// epp_pkg: shared types and constants for the EPP register bridge.
//   state_e : bridge FSM states (idle / acknowledge).
//   cyc_e   : type of the EPP cycle being acknowledged.
//   EPP_DATA_W, EPP_ADDR_W : EPP bus and address register widths.
package epp_pkg;

  localparam int unsigned EPP_DATA_W = 8;
  localparam int unsigned EPP_ADDR_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_e;

  typedef enum logic [1:0] {
    CYC_ADDR_WR,
    CYC_ADDR_RD,
    CYC_DATA_WR,
    CYC_DATA_RD
  } cyc_e;

  // Address cycles are released on astb, data cycles on dstb.
  function automatic logic cyc_is_addr(input cyc_e c);
    return (c == CYC_ADDR_WR) || (c == CYC_ADDR_RD);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage single-bit synchroniser for asynchronous EPP pins.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage to RST_VAL
//   d_i    : asynchronous input
//   q_o    : synchronised output (STAGES clk_i edges of latency)
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/epp_reg_bridge.sv
// epp_reg_bridge: Digilent EPP slave mapping host address/data cycles onto
// a bank of NUM_REGS byte registers.
//   mclk, rst_n            : system clock, asynchronous active-low reset
//   usb_astb, usb_dstb     : EPP address / data strobes (active low, async)
//   usb_write              : EPP direction, 0 = host write, 1 = host read
//   usb_db_i/_o/_oe        : split data bus towards the pad tristate
//   usb_wait               : EPP wait/acknowledge
//   reg_wr_data            : host-written slots, slot k at [8k+7:8k]
//   reg_wr_pulse           : one-cycle strobe per slot on host write
//   reg_rd_data            : machine status bytes returned on host reads
//   reg_rd_pulse           : one-cycle strobe per slot on host read
module epp_reg_bridge
  import epp_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AUTO_INC    = 1
) (
  input  logic                    mclk,
  input  logic                    rst_n,
  input  logic                    usb_astb,
  input  logic                    usb_dstb,
  input  logic                    usb_write,
  input  logic [EPP_DATA_W-1:0]   usb_db_i,
  output logic [EPP_DATA_W-1:0]   usb_db_o,
  output logic                    usb_db_oe,
  output logic                    usb_wait,
  output logic [NUM_REGS*8-1:0]   reg_wr_data,
  output logic [NUM_REGS-1:0]     reg_wr_pulse,
  input  logic [NUM_REGS*8-1:0]   reg_rd_data,
  output logic [NUM_REGS-1:0]     reg_rd_pulse
);

  // ---------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------
  logic astb_s, dstb_s, write_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_astb (
    .clk_i (mclk),
    .rst_ni(rst_n),
    .d_i   (usb_astb),
    .q_o   (astb_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dstb (
    .clk_i (mclk),
    .rst_ni(rst_n),
    .d_i   (usb_dstb),
    .q_o   (dstb_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_write (
    .clk_i (mclk),
    .rst_ni(rst_n),
    .d_i   (usb_write),
    .q_o   (write_s)
  );

  // The synchronisers come out of reset reading "released" even when the
  // pin is held low. Arming is withheld until the reset values have been
  // flushed so a strobe held across reset can never arm the bridge.
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   flushed;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= '0;
    end else begin
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign flushed = flush_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Address decode: one-hot slot hit and read-data mux (0 when out of range)
  // ---------------------------------------------------------------------
  logic [EPP_ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_REGS-1:0]   addr_hit;
  logic [EPP_DATA_W-1:0] rd_byte;

  always_comb begin
    addr_hit = '0;
    rd_byte  = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (addr_q == EPP_ADDR_W'(k)) begin
        addr_hit[k] = 1'b1;
        rd_byte     = reg_rd_data[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------
  state_e                state_q, state_d;
  cyc_e                  cyc_q, cyc_d;
  logic                  armed_q, armed_d;
  logic                  wait_q, wait_d;
  logic                  oe_q, oe_d;
  logic [EPP_DATA_W-1:0] dbo_q, dbo_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0]   rd_pulse_q, rd_pulse_d;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cyc_q      <= CYC_ADDR_WR;
      addr_q     <= '0;
      armed_q    <= 1'b0;
      wait_q     <= 1'b0;
      oe_q       <= 1'b0;
      dbo_q      <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      addr_q     <= addr_d;
      armed_q    <= armed_d;
      wait_q     <= wait_d;
      oe_q       <= oe_d;
      dbo_q      <= dbo_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  logic released;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    addr_d     = addr_q;
    armed_d    = armed_q;
    wait_d     = wait_q;
    oe_d       = oe_q;
    dbo_d      = dbo_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    rd_pulse_d = '0;
    released   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!astb_s && !dstb_s) begin
          // Both strobes low is a protocol error: disarm, no side effects.
          armed_d = 1'b0;
        end else if (!armed_q) begin
          if (astb_s && dstb_s && flushed) begin
            armed_d = 1'b1;
          end
        end else if (!astb_s) begin
          state_d = ST_ACK;
          wait_d  = 1'b1;
          if (!write_s) begin
            cyc_d  = CYC_ADDR_WR;
            addr_d = usb_db_i;
          end else begin
            cyc_d = CYC_ADDR_RD;
            dbo_d = addr_q;
            oe_d  = 1'b1;
          end
        end else if (!dstb_s) begin
          state_d = ST_ACK;
          wait_d  = 1'b1;
          if (!write_s) begin
            cyc_d      = CYC_DATA_WR;
            wr_pulse_d = addr_hit;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
              if (addr_hit[k]) begin
                regs_d[8*k +: 8] = usb_db_i;
              end
            end
          end else begin
            cyc_d      = CYC_DATA_RD;
            dbo_d      = rd_byte;
            oe_d       = 1'b1;
            rd_pulse_d = addr_hit;
          end
        end
      end

      ST_ACK: begin
        released = cyc_is_addr(cyc_q) ? astb_s : dstb_s;
        if (released) begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
          oe_d    = 1'b0;
          if (!cyc_is_addr(cyc_q) && (AUTO_INC != 0)) begin
            addr_d = addr_q + EPP_ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign usb_db_o     = dbo_q;
  assign usb_db_oe    = oe_q;
  assign usb_wait     = wait_q;
  assign reg_wr_data  = regs_q;
  assign reg_wr_pulse = wr_pulse_q;
  assign reg_rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_epp_reg_bridge.sv
// Bench for epp_reg_bridge: transaction-level model of the register bank,
// address register and acknowledge timing, checked against the DUT on every
// clock cycle, plus literal expectations for the directed scenarios.
module tb_epp_reg_bridge;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned SYNC     = 2;
  localparam int unsigned AUTO_INC = 1;
  localparam int unsigned W        = NUM_REGS * 8;

  logic                mclk = 1'b0;
  logic                rst_n;
  logic                usb_astb, usb_dstb, usb_write;
  logic [7:0]          usb_db_i, usb_db_o;
  logic                usb_db_oe, usb_wait;
  logic [W-1:0]        reg_wr_data, reg_rd_data;
  logic [NUM_REGS-1:0] reg_wr_pulse, reg_rd_pulse;

  always #5 mclk = ~mclk;

  epp_reg_bridge #(
    .NUM_REGS   (NUM_REGS),
    .SYNC_STAGES(SYNC),
    .AUTO_INC   (AUTO_INC)
  ) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .usb_astb    (usb_astb),
    .usb_dstb    (usb_dstb),
    .usb_write   (usb_write),
    .usb_db_i    (usb_db_i),
    .usb_db_o    (usb_db_o),
    .usb_db_oe   (usb_db_oe),
    .usb_wait    (usb_wait),
    .reg_wr_data (reg_wr_data),
    .reg_wr_pulse(reg_wr_pulse),
    .reg_rd_data (reg_rd_data),
    .reg_rd_pulse(reg_rd_pulse)
  );

  // Model state
  logic [7:0]          m_regs [NUM_REGS];
  logic [7:0]          rd_src [NUM_REGS];
  logic [7:0]          m_addr;
  logic                exp_wait, exp_oe;
  logic [7:0]          exp_dbo;
  logic [NUM_REGS-1:0] exp_wr_pulse, exp_rd_pulse;
  logic [NUM_REGS-1:0] last_wr, last_rd;
  bit                  cur_is_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always_comb begin
    reg_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) reg_rd_data[8*k +: 8] = rd_src[k];
  end

  function automatic logic [W-1:0] model_regs();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REGS; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'h00;
    m_addr       = 8'h00;
    exp_wait     = 1'b0;
    exp_oe       = 1'b0;
    exp_dbo      = 8'h00;
    exp_wr_pulse = '0;
    exp_rd_pulse = '0;
  endfunction

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge mclk);
      #1;
      check("usb_wait", W'(usb_wait), W'(exp_wait));
      check("usb_db_oe", W'(usb_db_oe), W'(exp_oe));
      check("reg_wr_pulse", W'(reg_wr_pulse), W'(exp_wr_pulse));
      check("reg_rd_pulse", W'(reg_rd_pulse), W'(exp_rd_pulse));
      check("reg_wr_data", reg_wr_data, model_regs());
      if (exp_oe) check("usb_db_o", W'(usb_db_o), W'(exp_dbo));
    end
  end

  // Begin an EPP cycle; returns one cycle after the bridge acknowledges,
  // with the pulses of the acknowledge cycle captured in last_wr/last_rd.
  task automatic cyc_begin(input bit is_addr, input bit is_read, input logic [7:0] data);
    @(negedge mclk);
    usb_write = is_read;
    usb_db_i  = data;
    if (is_addr) usb_astb = 1'b0;
    else         usb_dstb = 1'b0;
    cur_is_addr = is_addr;
    repeat (SYNC) @(negedge mclk);
    exp_wait = 1'b1;
    if (is_addr && !is_read) begin
      m_addr = data;
    end else if (is_addr) begin
      exp_dbo = m_addr;
      exp_oe  = 1'b1;
    end else if (!is_read) begin
      if (m_addr < NUM_REGS) begin
        m_regs[int'(m_addr)]          = data;
        exp_wr_pulse[int'(m_addr)]    = 1'b1;
      end
    end else begin
      exp_oe  = 1'b1;
      exp_dbo = (m_addr < NUM_REGS) ? rd_src[int'(m_addr)] : 8'h00;
      if (m_addr < NUM_REGS) exp_rd_pulse[int'(m_addr)] = 1'b1;
    end
    @(negedge mclk);
    last_wr      = reg_wr_pulse;
    last_rd      = reg_rd_pulse;
    exp_wr_pulse = '0;
    exp_rd_pulse = '0;
  endtask

  task automatic cyc_end();
    @(negedge mclk);
    usb_astb = 1'b1;
    usb_dstb = 1'b1;
    repeat (SYNC) @(negedge mclk);
    exp_wait = 1'b0;
    exp_oe   = 1'b0;
    if (!cur_is_addr && AUTO_INC != 0) m_addr = m_addr + 8'd1;
    @(negedge mclk);
  endtask

  task automatic xfer(input bit is_addr, input bit is_read, input logic [7:0] data);
    cyc_begin(is_addr, is_read, data);
    cyc_end();
  endtask

  initial begin
    rst_n     = 1'b0;
    usb_astb  = 1'b1;
    usb_dstb  = 1'b1;
    usb_write = 1'b0;
    usb_db_i  = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) rd_src[k] = 8'(k * 17 + 8'h5A);
    rd_src[3] = 8'h3C;
    model_reset();
    repeat (3) @(negedge mclk);
    check("reset reg_wr_data", reg_wr_data, '0);
    check("reset usb_wait", W'(usb_wait), W'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge mclk);

    // 1: address 0x05, data write 0xA7
    xfer(1, 0, 8'h05);
    cyc_begin(0, 0, 8'hA7);
    check("t1 wait up", W'(usb_wait), W'(1));
    check("t1 slot5", W'(reg_wr_data[47:40]), W'(8'hA7));
    check("t1 wr_pulse", W'(last_wr), W'(16'h0020));
    cyc_end();

    // 2: address 0x03, data read of 0x3C
    xfer(1, 0, 8'h03);
    cyc_begin(0, 1, 8'h00);
    check("t2 db_o", W'(usb_db_o), W'(8'h3C));
    check("t2 oe", W'(usb_db_oe), W'(1));
    check("t2 rd_pulse", W'(last_rd), W'(16'h0008));
    cyc_end();

    // 3: burst across the end of the bank
    xfer(1, 0, 8'h0E);
    xfer(0, 0, 8'h11);
    xfer(0, 0, 8'h22);
    cyc_begin(0, 0, 8'h33);
    check("t3 dropped pulse", W'(last_wr), W'(0));
    cyc_end();
    check("t3 slot14", W'(reg_wr_data[119:112]), W'(8'h11));
    check("t3 slot15", W'(reg_wr_data[127:120]), W'(8'h22));
    cyc_begin(1, 1, 8'h00);
    check("t3 addr read", W'(usb_db_o), W'(8'h11));
    cyc_end();

    // 4: out-of-range read at 0xFF, address wraps to 0
    xfer(1, 0, 8'hFF);
    cyc_begin(0, 1, 8'h00);
    check("t4 db_o", W'(usb_db_o), W'(8'h00));
    check("t4 rd_pulse", W'(last_rd), W'(0));
    cyc_end();
    cyc_begin(1, 1, 8'h00);
    check("t4 wrap addr", W'(usb_db_o), W'(8'h00));
    check("t4 oe", W'(usb_db_oe), W'(1));
    cyc_end();

    // 5: both strobes low is ignored, then normal operation resumes
    @(negedge mclk);
    usb_write = 1'b0;
    usb_db_i  = 8'h77;
    usb_astb  = 1'b0;
    usb_dstb  = 1'b0;
    repeat (8) @(negedge mclk);
    check("t5 no wait", W'(usb_wait), W'(0));
    usb_astb = 1'b1;
    usb_dstb = 1'b1;
    repeat (5) @(negedge mclk);
    xfer(1, 0, 8'h42);
    cyc_begin(1, 1, 8'h00);
    check("t5 addr read", W'(usb_db_o), W'(8'h42));
    cyc_end();

    // 6: reset while dstb is held low mid-write
    @(negedge mclk);
    usb_write = 1'b0;
    usb_db_i  = 8'h99;
    usb_dstb  = 1'b0;
    @(negedge mclk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    repeat (8) @(negedge mclk);
    check("t6 no wait", W'(usb_wait), W'(0));
    check("t6 regs clear", reg_wr_data, '0);
    usb_dstb = 1'b1;
    repeat (5) @(negedge mclk);
    cyc_begin(0, 0, 8'h99);
    check("t6 slot0", W'(reg_wr_data[7:0]), W'(8'h99));
    check("t6 wr_pulse", W'(last_wr), W'(16'h0001));
    cyc_end();

    repeat (4) @(negedge mclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
